// File: rtl/instr_mem_prog_if.sv
// Fetch and program port bundle for the loadable instruction memory.
// The master side is the CPU/bootloader; the slave side is the memory.
interface instr_mem_prog_if #(
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_fault;
  logic              prog_start;
  logic [31:0]       prog_base;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              busy;
  logic              prog_overflow;

  modport master (
    output fetch_en, fetch_addr, prog_start, prog_base, prog_valid, prog_data,
    input  fetch_data, fetch_valid, fetch_fault, prog_ready, busy, prog_overflow
  );

  modport slave (
    input  fetch_en, fetch_addr, prog_start, prog_base, prog_valid, prog_data,
    output fetch_data, fetch_valid, fetch_fault, prog_ready, busy, prog_overflow
  );
endinterface

// File: rtl/instr_mem_prog.sv
// Run-time loadable instruction memory: self-clears to FILL_WORD after reset,
// takes a word stream on the program port and serves registered fetches.
module instr_mem_prog #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'h08000000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_mem_prog_if.slave       bus
);

  typedef enum logic [1:0] {INIT, IDLE, PROG} state_t;

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_fault_q, fetch_fault_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              base_ok;
  logic [ADDR_W-1:0] base_idx;
  logic              fetch_ok;
  logic [ADDR_W-1:0] fetch_idx;

  assign base_ok   = (bus.prog_base[1:0] == 2'b00) && (bus.prog_base[31:ADDR_W+2] == '0);
  assign base_idx  = bus.prog_base[ADDR_W+1:2];
  assign fetch_ok  = (bus.fetch_addr[1:0] == 2'b00) && (bus.fetch_addr[31:ADDR_W+2] == '0);
  assign fetch_idx = bus.fetch_addr[ADDR_W+1:2];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wptr_d    = wptr_q;
    ovf_d     = ovf_q;
    we        = 1'b0;
    waddr     = wptr_q;
    wdata     = bus.prog_data;
    case (state_q)
      INIT: begin
        we        = 1'b1;
        waddr     = clr_cnt_q;
        wdata     = FILL_WORD;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        if (bus.prog_start) begin
          if (base_ok) begin
            state_d = PROG;
            wptr_d  = base_idx;
            ovf_d   = 1'b0;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      PROG: begin
        if (bus.prog_start && !base_ok) begin
          // A bad re-base aborts the burst rather than writing somewhere arbitrary.
          ovf_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (bus.prog_start) begin
            waddr  = base_idx;
            wptr_d = base_idx;
            ovf_d  = 1'b0;
          end
          if (bus.prog_valid) begin
            we = 1'b1;
            if (waddr == LAST_IDX) begin
              ovf_d   = 1'b1;
              state_d = IDLE;
            end else begin
              wptr_d = waddr + 1'b1;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    fetch_data_d  = fetch_data_q;
    fetch_fault_d = fetch_fault_q;
    fetch_valid_d = bus.fetch_en && (state_q != INIT);
    if (fetch_valid_d) begin
      fetch_fault_d = !fetch_ok;
      fetch_data_d  = fetch_ok ? mem_q[fetch_idx] : FILL_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= INIT;
      clr_cnt_q     <= '0;
      wptr_q        <= '0;
      ovf_q         <= 1'b0;
      fetch_data_q  <= FILL_WORD;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wptr_q        <= wptr_d;
      ovf_q         <= ovf_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Storage array: the fetch register samples the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.fetch_data    = fetch_data_q;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_fault   = fetch_fault_q;
  assign bus.prog_ready    = (state_q == PROG);
  assign bus.busy          = (state_q == INIT);
  assign bus.prog_overflow = ovf_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog with ADDR_W=4 (16 words).
module tb_instr_mem_prog;

  localparam logic [31:0] FILL = 32'h08000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_mem_prog_if #(.DATA_W(32)) bus ();

  instr_mem_prog #(.ADDR_W(4), .DATA_W(32), .FILL_WORD(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        st;
    logic [31:0] base;
    logic        pv;
    logic [31:0] pd;
    logic        ev;
    logic        ef;
    logic [31:0] ed;
    logic        er;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] addr, input logic st,
                     input logic [31:0] base, input logic pv, input logic [31:0] pd,
                     input logic ev, input logic ef, input logic [31:0] ed,
                     input logic er, input logic eo);
    vec_t v;
    v.en = en; v.addr = addr; v.st = st; v.base = base; v.pv = pv; v.pd = pd;
    v.ev = ev; v.ef = ef; v.ed = ed; v.er = er; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.fetch_en = 1'b0; bus.fetch_addr = '0; bus.prog_start = 1'b0;
    bus.prog_base = '0; bus.prog_valid = 1'b0; bus.prog_data = '0;
  endtask

  task automatic wait_clear(input string nm);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      step();
      n++;
      chk({nm, " valid during busy"}, {31'b0, bus.fetch_valid}, 32'd0);
    end
    chk({nm, " busy cycles"}, n, 32'd16);
  endtask

  initial begin
    //      en addr          st base          pv data          ev ef exp_data      rdy ovf
    add(1, 32'h3C, 0, 0,     0, 0,            1, 0, FILL,          0, 0);
    add(0, 0,      1, 32'h06,0, 0,            0, 0, FILL,          0, 1);
    add(0, 0,      1, 32'h40,0, 0,            0, 0, FILL,          0, 1);
    add(0, 0,      1, 32'h10,0, 0,            0, 0, FILL,          1, 0);
    add(0, 0,      0, 0,     1, 32'h20080040, 0, 0, FILL,          1, 0);
    add(0, 0,      0, 0,     1, 32'hac080000, 0, 0, FILL,          1, 0);
    add(0, 0,      0, 0,     1, 32'h3c174000, 0, 0, FILL,          1, 0);
    add(1, 32'h10, 0, 0,     0, 0,            1, 0, 32'h20080040,  1, 0);
    add(1, 32'h14, 0, 0,     0, 0,            1, 0, 32'hac080000,  1, 0);
    add(1, 32'h18, 0, 0,     0, 0,            1, 0, 32'h3c174000,  1, 0);
    add(1, 32'h06, 0, 0,     0, 0,            1, 1, FILL,          1, 0);
    add(1, 32'h40, 0, 0,     0, 0,            1, 1, FILL,          1, 0);
    add(0, 0,      0, 0,     0, 0,            0, 1, FILL,          1, 0);
    add(1, 32'h1C, 0, 0,     0, 0,            1, 0, FILL,          1, 0);
    add(1, 32'h14, 1, 32'h14,1, 32'hDEADBEEF, 1, 0, 32'hac080000,  1, 0);
    add(1, 32'h14, 0, 0,     0, 0,            1, 0, 32'hDEADBEEF,  1, 0);
    add(0, 0,      1, 32'h38,0, 0,            0, 0, 32'hDEADBEEF,  1, 0);
    add(0, 0,      0, 0,     1, 32'h0000AAAA, 0, 0, 32'hDEADBEEF,  1, 0);
    add(0, 0,      0, 0,     1, 32'h0000BBBB, 0, 0, 32'hDEADBEEF,  0, 1);
    add(0, 0,      0, 0,     1, 32'h0000CCCC, 0, 0, 32'hDEADBEEF,  0, 1);
    add(1, 32'h38, 0, 0,     0, 0,            1, 0, 32'h0000AAAA,  0, 1);
    add(1, 32'h3C, 0, 0,     0, 0,            1, 0, 32'h0000BBBB,  0, 1);
    add(1, 32'h00, 0, 0,     0, 0,            1, 0, FILL,          0, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    chk("rst busy",    {31'b0, bus.busy},          32'd1);
    chk("rst valid",   {31'b0, bus.fetch_valid},   32'd0);
    chk("rst fault",   {31'b0, bus.fetch_fault},   32'd0);
    chk("rst ready",   {31'b0, bus.prog_ready},    32'd0);
    chk("rst ovf",     {31'b0, bus.prog_overflow}, 32'd0);
    chk("rst data",    bus.fetch_data,             FILL);
    reset = 1'b0;
    bus.fetch_en = 1'b1;
    bus.fetch_addr = 32'h0;
    wait_clear("init");
    idle_inputs();

    foreach (vecs[i]) begin
      bus.fetch_en   = vecs[i].en;
      bus.fetch_addr = vecs[i].addr;
      bus.prog_start = vecs[i].st;
      bus.prog_base  = vecs[i].base;
      bus.prog_valid = vecs[i].pv;
      bus.prog_data  = vecs[i].pd;
      step();
      chk($sformatf("v%0d valid", i), {31'b0, bus.fetch_valid},   {31'b0, vecs[i].ev});
      chk($sformatf("v%0d fault", i), {31'b0, bus.fetch_fault},   {31'b0, vecs[i].ef});
      chk($sformatf("v%0d data",  i), bus.fetch_data,             vecs[i].ed);
      chk($sformatf("v%0d ready", i), {31'b0, bus.prog_ready},    {31'b0, vecs[i].er});
      chk($sformatf("v%0d ovf",   i), {31'b0, bus.prog_overflow}, {31'b0, vecs[i].eo});
    end
    idle_inputs();

    // Reset in the middle of a burst, after two words have been written.
    bus.prog_start = 1'b1; bus.prog_base = 32'h0;
    step();
    bus.prog_start = 1'b0; bus.prog_valid = 1'b1; bus.prog_data = 32'h12345678;
    step();
    bus.prog_data = 32'h9ABCDEF0;
    step();
    chk("burst ready", {31'b0, bus.prog_ready}, 32'd1);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("midrst busy",  {31'b0, bus.busy},          32'd1);
    chk("midrst ready", {31'b0, bus.prog_ready},    32'd0);
    chk("midrst ovf",   {31'b0, bus.prog_overflow}, 32'd0);
    step();
    reset = 1'b0;
    wait_clear("reclear");
    for (int i = 0; i < 16; i++) begin
      bus.fetch_en = 1'b1;
      bus.fetch_addr = i * 4;
      step();
      chk($sformatf("clr idx%0d data", i), bus.fetch_data, FILL);
      chk($sformatf("clr idx%0d valid", i), {31'b0, bus.fetch_valid}, 32'd1);
    end
    chk("clr ovf", {31'b0, bus.prog_overflow}, 32'd0);
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
